// File: rtl/io_port_bank.sv
`default_nettype none
// ============================================================================
//  Module   : io_port_bank
//  Purpose  : Memory-mapped multi-channel I/O bank. Decodes a window of
//             NCH+3 words at BASE_ADDR into NCH input FIFOs (valid/ready),
//             NCH output holding registers (valid/ready), a status word,
//             a write-1-to-clear overrun error word and an optional
//             interrupt mask.
//  Options  : IO_PORT_IRQ_EN - enables the interrupt mask register and ioIrq.
//             When undefined, ioIrq is 0 and the mask offset reads 0.
//  Revision : 1.0 - initial release
// ============================================================================
module io_port_bank #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                NCH       = 4,
    parameter int                IN_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     memAddr,
    input  logic                  writeMem,
    input  logic                  readMem,
    input  logic [DATA_W-1:0]     memWriteData,
    output logic [DATA_W-1:0]     ioRdata,
    output logic                  ioHit,
    input  logic [NCH*DATA_W-1:0] ioInput,
    input  logic [NCH-1:0]        ioInValid,
    output logic [NCH-1:0]        ioInReady,
    output logic [NCH*DATA_W-1:0] ioOutput,
    output logic [NCH-1:0]        ioOutValid,
    input  logic [NCH-1:0]        ioOutReady,
    output logic                  ioIrq
);

    localparam int                c_PTR_W      = $clog2(IN_DEPTH);
    localparam int                c_CNT_W      = c_PTR_W + 1;
    localparam int                c_WIN        = NCH + 3;
    localparam logic [ADDR_W-1:0] c_OFF_STATUS = ADDR_W'(NCH);
    localparam logic [ADDR_W-1:0] c_OFF_ERR    = ADDR_W'(NCH + 1);
    localparam logic [ADDR_W-1:0] c_OFF_MASK   = ADDR_W'(NCH + 2);

    // Address decode: unsigned wrap makes addresses below BASE_ADDR miss too
    logic [ADDR_W-1:0] w_offset;
    logic              w_rdStrobe;
    logic              w_wrStrobe;

    assign w_offset   = memAddr - BASE_ADDR;
    assign ioHit      = (w_offset < ADDR_W'(c_WIN));
    assign w_rdStrobe = readMem & ioHit;
    assign w_wrStrobe = writeMem & ioHit;

    logic [NCH-1:0]    w_notEmpty;
    logic [NCH-1:0]    w_outValid;
    logic [NCH-1:0]    w_errSet;
    logic [DATA_W-1:0] w_head [NCH];
    logic [NCH-1:0]    w_mask;

    genvar gc;
    generate
        for (gc = 0; gc < NCH; gc++) begin : g_ch
            logic [DATA_W-1:0]  r_mem [IN_DEPTH];
            logic [c_PTR_W-1:0] r_wrPtr;
            logic [c_PTR_W-1:0] r_rdPtr;
            logic [c_CNT_W-1:0] r_count;
            logic [DATA_W-1:0]  r_outData;
            logic               r_outValid;
            logic               w_sel;
            logic               w_push;
            logic               w_pop;
            logic               w_wrSel;
            logic               w_load;

            assign w_sel          = (w_offset == ADDR_W'(gc));
            assign w_notEmpty[gc] = (r_count != '0);
            // Ready depends only on the registered occupancy, never on a same-cycle pop
            assign ioInReady[gc]  = (r_count != c_CNT_W'(IN_DEPTH));
            assign w_push         = ioInValid[gc] & ioInReady[gc];
            assign w_pop          = w_rdStrobe & w_sel & w_notEmpty[gc];
            assign w_head[gc]     = r_mem[r_rdPtr];

            // FIFO pointers and occupancy; simultaneous push and pop leaves the count alone
            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_wrPtr <= '0;
                    r_rdPtr <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
                    if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
                    if (w_push && !w_pop)
                        r_count <= r_count + 1'b1;
                    else if (w_pop && !w_push)
                        r_count <= r_count - 1'b1;
                end
            end

            // FIFO storage; contents are invalidated by the pointer reset
            always_ff @(posedge CLK) begin
                if (w_push) r_mem[r_wrPtr] <= ioInput[gc*DATA_W +: DATA_W];
            end

            // A write lands if the slot is free or is being drained this cycle
            assign w_wrSel      = w_wrStrobe & w_sel;
            assign w_load       = w_wrSel & (~r_outValid | ioOutReady[gc]);
            assign w_errSet[gc] = w_wrSel & r_outValid & ~ioOutReady[gc];

            // Output holding register with valid/ready handshake
            always_ff @(posedge CLK) begin
                if (reset) begin
                    r_outData  <= '0;
                    r_outValid <= 1'b0;
                end else if (w_load) begin
                    r_outData  <= memWriteData;
                    r_outValid <= 1'b1;
                end else if (r_outValid && ioOutReady[gc]) begin
                    r_outValid <= 1'b0;
                end
            end

            assign ioOutput[gc*DATA_W +: DATA_W] = r_outData;
            assign w_outValid[gc]                = r_outValid;
        end
    endgenerate

    assign ioOutValid = w_outValid;

    // Overrun error register: new overruns win over a same-cycle clear
    logic [NCH-1:0] r_err;
    always_ff @(posedge CLK) begin
        if (reset)
            r_err <= '0;
        else if (w_wrStrobe && (w_offset == c_OFF_ERR))
            r_err <= (r_err & ~memWriteData[NCH-1:0]) | w_errSet;
        else
            r_err <= r_err | w_errSet;
    end

`ifdef IO_PORT_IRQ_EN
    logic [NCH-1:0] r_mask;
    logic           r_irq;

    // Interrupt mask register
    always_ff @(posedge CLK) begin
        if (reset)
            r_mask <= '0;
        else if (w_wrStrobe && (w_offset == c_OFF_MASK))
            r_mask <= memWriteData[NCH-1:0];
    end

    // Registered interrupt: any masked channel holding input data
    always_ff @(posedge CLK) begin
        if (reset) r_irq <= 1'b0;
        else       r_irq <= |(w_notEmpty & r_mask);
    end

    assign w_mask = r_mask;
    assign ioIrq  = r_irq;
`else
    assign w_mask = '0;
    assign ioIrq  = 1'b0;
`endif

    // Read mux: pre-write register values; empty FIFOs and misses read as 0
    logic [DATA_W-1:0] w_readData;
    always_comb begin
        w_readData = '0;
        for (int c = 0; c < NCH; c++) begin
            if ((w_offset == ADDR_W'(c)) && w_notEmpty[c])
                w_readData = w_head[c];
        end
        if (w_offset == c_OFF_STATUS) begin
            w_readData                = '0;
            w_readData[NCH-1:0]       = w_notEmpty;
            w_readData[2*NCH-1:NCH]   = w_outValid;
        end
        if (w_offset == c_OFF_ERR) begin
            w_readData          = '0;
            w_readData[NCH-1:0] = r_err;
        end
        if (w_offset == c_OFF_MASK) begin
            w_readData          = '0;
            w_readData[NCH-1:0] = w_mask;
        end
    end

    // Registered read data, held until the next read strobe
    logic [DATA_W-1:0] r_rdata;
    always_ff @(posedge CLK) begin
        if (reset)
            r_rdata <= '0;
        else if (readMem)
            r_rdata <= w_rdStrobe ? w_readData : '0;
    end

    assign ioRdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_io_port_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_io_port_bank
//  Purpose  : Self-checking bench for io_port_bank (NCH=4, 16-bit, depth 4).
//             Queue-based reference model, vector table, directed corner
//             sequences and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_io_port_bank;

    localparam int          NCH   = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'hFF00;
`ifdef IO_PORT_IRQ_EN
    localparam bit          IRQ_ON = 1'b1;
`else
    localparam bit          IRQ_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] memAddr;
    logic        writeMem;
    logic        readMem;
    logic [15:0] memWriteData;
    logic [15:0] ioRdata;
    logic        ioHit;
    logic [63:0] ioInput;
    logic [3:0]  ioInValid;
    logic [3:0]  ioInReady;
    logic [63:0] ioOutput;
    logic [3:0]  ioOutValid;
    logic [3:0]  ioOutReady;
    logic        ioIrq;

    io_port_bank dut (
        .CLK          (CLK),
        .reset        (reset),
        .memAddr      (memAddr),
        .writeMem     (writeMem),
        .readMem      (readMem),
        .memWriteData (memWriteData),
        .ioRdata      (ioRdata),
        .ioHit        (ioHit),
        .ioInput      (ioInput),
        .ioInValid    (ioInValid),
        .ioInReady    (ioInReady),
        .ioOutput     (ioOutput),
        .ioOutValid   (ioOutValid),
        .ioOutReady   (ioOutReady),
        .ioIrq        (ioIrq)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq [NCH][$];
    logic [15:0] mOut [NCH];
    logic [3:0]  mOutV, mErr, mMask;
    logic        mIrq;
    logic [15:0] mRdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic inWindow(input logic [15:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + NCH + 3);
    endfunction

    function automatic logic [3:0] notEmpty();
        logic [3:0] ne;
        for (int c = 0; c < NCH; c++) ne[c] = (mq[c].size() != 0);
        return ne;
    endfunction

    function automatic logic [15:0] regVal(input int off);
        if (off < NCH)      return (mq[off].size() != 0) ? mq[off][0] : 16'h0;
        if (off == NCH)     return {8'h0, mOutV, notEmpty()};
        if (off == NCH + 1) return {12'h0, mErr};
        if (off == NCH + 2) return {12'h0, mMask};
        return 16'h0;
    endfunction

    // Apply the spec's rules to the current inputs, producing post-edge state
    task automatic modelUpdate();
        logic       hit;
        int         off;
        logic [3:0] acc, errSet;
        logic       nextIrq;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin mq[c].delete(); mOut[c] = 16'h0; end
            mOutV = 0; mErr = 0; mMask = 0; mIrq = 0; mRdata = 0;
            return;
        end
        hit = inWindow(memAddr);
        off = int'(memAddr) - int'(BASE);
        if (readMem) mRdata = hit ? regVal(off) : 16'h0;
        nextIrq = |(notEmpty() & mMask);
        for (int c = 0; c < NCH; c++) acc[c] = ioInValid[c] && (mq[c].size() < DEPTH);
        if (readMem && hit && off < NCH && mq[off].size() > 0) void'(mq[off].pop_front());
        for (int c = 0; c < NCH; c++) if (acc[c]) mq[c].push_back(ioInput[c*16 +: 16]);
        errSet = 0;
        for (int c = 0; c < NCH; c++) begin
            if (writeMem && hit && off == c) begin
                if (!mOutV[c] || ioOutReady[c]) begin mOut[c] = memWriteData; mOutV[c] = 1'b1; end
                else errSet[c] = 1'b1;
            end else if (mOutV[c] && ioOutReady[c]) begin
                mOutV[c] = 1'b0;
            end
        end
        if (writeMem && hit && off == NCH + 1) mErr = mErr & ~memWriteData[3:0];
        mErr = mErr | errSet;
        if (IRQ_ON && writeMem && hit && off == NCH + 2) mMask = memWriteData[3:0];
        mIrq = nextIrq;
    endtask

    // One clock: check decode mid-cycle, advance model, compare after the edge
    task automatic step();
        logic [3:0] rdy;
        #4;
        chk("ioHit", ioHit, inWindow(memAddr));
        modelUpdate();
        @(posedge CLK);
        #1;
        for (int c = 0; c < NCH; c++) rdy[c] = (mq[c].size() < DEPTH);
        chk("model rdata", ioRdata, mRdata);
        chk("model inReady", ioInReady, rdy);
        chk("model outValid", ioOutValid, mOutV);
        chk("model output", ioOutput, {mOut[3], mOut[2], mOut[1], mOut[0]});
        chk("model irq", ioIrq, mIrq);
    endtask

    task automatic idle();
        memAddr = 16'h0; writeMem = 0; readMem = 0; memWriteData = 16'h0;
        ioInValid = 0; ioOutReady = 0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        wr, rd;
        logic [15:0] wdata;
        logic [3:0]  inValid;
        logic [15:0] din;
        logic [3:0]  outReady;
        logic [15:0] expRd;
        logic [3:0]  expInRdy;
        logic [3:0]  expOutV;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] a, input logic w, input logic r,
                                input logic [15:0] wd, input logic [3:0] iv, input logic [15:0] d,
                                input logic [3:0] orr, input logic [15:0] er,
                                input logic [3:0] eir, input logic [3:0] eov);
        vec_t v;
        v.addr = a; v.wr = w; v.rd = r; v.wdata = wd; v.inValid = iv; v.din = d;
        v.outReady = orr; v.expRd = er; v.expInRdy = eir; v.expOutV = eov;
        return v;
    endfunction

    vec_t tbl [18];

    initial begin
        //            addr     wr rd wdata    inV   din      oRdy  expRd    inRdy oV
        tbl[0]  = mk(16'hFF04, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'h0000, 4'hF, 4'h0);
        tbl[1]  = mk(16'h0000, 0, 0, 16'h0,   4'h2, 16'hA001,4'h0, 16'h0000, 4'hF, 4'h0);
        tbl[2]  = mk(16'h0000, 0, 0, 16'h0,   4'h2, 16'hA002,4'h0, 16'h0000, 4'hF, 4'h0);
        tbl[3]  = mk(16'h0000, 0, 0, 16'h0,   4'h2, 16'hA003,4'h0, 16'h0000, 4'hF, 4'h0);
        tbl[4]  = mk(16'h0000, 0, 0, 16'h0,   4'h2, 16'hA004,4'h0, 16'h0000, 4'hD, 4'h0);
        tbl[5]  = mk(16'h0000, 0, 0, 16'h0,   4'h2, 16'hA005,4'h0, 16'h0000, 4'hD, 4'h0);
        tbl[6]  = mk(16'hFF04, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'h0002, 4'hD, 4'h0);
        tbl[7]  = mk(16'hFF01, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'hA001, 4'hF, 4'h0);
        tbl[8]  = mk(16'hFF01, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'hA002, 4'hF, 4'h0);
        tbl[9]  = mk(16'hFF01, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'hA003, 4'hF, 4'h0);
        tbl[10] = mk(16'hFF01, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'hA004, 4'hF, 4'h0);
        tbl[11] = mk(16'hFF01, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'h0000, 4'hF, 4'h0);
        tbl[12] = mk(16'hFF03, 1, 0, 16'h55AA,4'h0, 16'h0,   4'h0, 16'h0000, 4'hF, 4'h8);
        tbl[13] = mk(16'hFF04, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'h0080, 4'hF, 4'h8);
        tbl[14] = mk(16'h1234, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'h0000, 4'hF, 4'h8);
        tbl[15] = mk(16'hFF03, 1, 0, 16'h0000,4'h0, 16'h0,   4'h8, 16'h0000, 4'hF, 4'h8);
        tbl[16] = mk(16'h0000, 0, 0, 16'h0,   4'h0, 16'h0,   4'h8, 16'h0000, 4'hF, 4'h0);
        tbl[17] = mk(16'hFF05, 0, 1, 16'h0,   4'h0, 16'h0,   4'h0, 16'h0000, 4'hF, 4'h0);

        idle();
        ioInput = 64'h0;
        reset = 1'b1;
        step();
        step();
        chk("reset inReady", ioInReady, 4'hF);
        chk("reset outValid", ioOutValid, 4'h0);
        chk("reset rdata", ioRdata, 16'h0);
        chk("reset irq", ioIrq, 1'b0);
        reset = 1'b0;

        // Vector table: reset status, channel-1 fill/drain, output basics
        for (int i = 0; i < 18; i++) begin
            memAddr = tbl[i].addr; writeMem = tbl[i].wr; readMem = tbl[i].rd;
            memWriteData = tbl[i].wdata; ioInValid = tbl[i].inValid;
            ioInput = {4{tbl[i].din}}; ioOutReady = tbl[i].outReady;
            step();
            chk($sformatf("vec%0d rdata", i), ioRdata, tbl[i].expRd);
            chk($sformatf("vec%0d inReady", i), ioInReady, tbl[i].expInRdy);
            chk($sformatf("vec%0d outValid", i), ioOutValid, tbl[i].expOutV);
        end
        chk("vec ch3 output", ioOutput[63:48], 16'h0000);

        // Overrun on channel 2, W1C with simultaneous read, then drain
        idle(); memAddr = 16'hFF02; writeMem = 1; memWriteData = 16'h1234; step();
        chk("ovr load", ioOutput[47:32], 16'h1234);
        chk("ovr valid", ioOutValid[2], 1'b1);
        memWriteData = 16'h5678; step();
        chk("ovr keep", ioOutput[47:32], 16'h1234);
        idle(); memAddr = 16'hFF05; readMem = 1; step();
        chk("ovr err", ioRdata, 16'h0004);
        writeMem = 1; memWriteData = 16'h0004; step();
        chk("ovr err pre-clear", ioRdata, 16'h0004);
        writeMem = 0; step();
        chk("ovr err cleared", ioRdata, 16'h0000);
        idle(); ioOutReady = 4'b0100; step();
        chk("ovr drain", ioOutValid[2], 1'b0);

        // Write on the handshake edge of channel 0
        idle(); memAddr = 16'hFF00; writeMem = 1; memWriteData = 16'h1111; step();
        memWriteData = 16'hBEEF; ioOutReady = 4'b0001; step();
        chk("hs data", ioOutput[15:0], 16'hBEEF);
        chk("hs valid", ioOutValid[0], 1'b1);
        idle(); memAddr = 16'hFF05; readMem = 1; step();
        chk("hs err", ioRdata, 16'h0000);
        idle(); ioOutReady = 4'b0001; step();
        chk("hs drain", ioOutValid[0], 1'b0);

        // Interrupt on channel 3
        idle(); memAddr = 16'hFF06; writeMem = 1; memWriteData = 16'h0008; step();
        idle(); memAddr = 16'hFF06; readMem = 1; step();
        chk("irq mask read", ioRdata, IRQ_ON ? 16'h0008 : 16'h0000);
        idle(); ioInValid = 4'b1000; ioInput = {16'hC0DE, 48'h0}; step();
        chk("irq push edge", ioIrq, 1'b0);
        idle(); step();
        chk("irq rise", ioIrq, IRQ_ON);
        memAddr = 16'hFF03; readMem = 1; step();
        chk("irq pop data", ioRdata, 16'hC0DE);
        chk("irq pop edge", ioIrq, IRQ_ON);
        idle(); step();
        chk("irq fall", ioIrq, 1'b0);
        memAddr = 16'hFF06; writeMem = 1; memWriteData = 16'h0; step();

        // Reset in the middle of traffic
        idle(); ioInValid = 4'b0011; ioInput = 64'h1111_2222_3333_4444; step();
        memAddr = 16'hFF01; writeMem = 1; memWriteData = 16'h7777; step();
        idle(); memAddr = 16'hFF04; readMem = 1; step();
        chk("pre-rst status", ioRdata, 16'h0023);
        idle(); reset = 1'b1; step();
        reset = 1'b0;
        chk("rst outValid", ioOutValid, 4'h0);
        chk("rst output", ioOutput, 64'h0);
        chk("rst inReady", ioInReady, 4'hF);
        chk("rst rdata", ioRdata, 16'h0);
        memAddr = 16'hFF04; readMem = 1; step();
        chk("rst status", ioRdata, 16'h0000);
        memAddr = 16'hFF00; step();
        chk("rst empty read", ioRdata, 16'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            reset = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 9);
            if (r < 8)       memAddr = BASE + 16'(r);
            else if (r == 8) memAddr = BASE - 16'd1;
            else             memAddr = 16'($urandom);
            writeMem     = ($urandom_range(0, 2) == 0);
            readMem      = ($urandom_range(0, 1) == 0);
            memWriteData = 16'($urandom);
            ioInValid    = 4'($urandom);
            ioInput      = {32'($urandom), 32'($urandom)};
            ioOutReady   = 4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_port_bank.md
# io_port_bank

Parametrised memory-mapped I/O block that replaces the single fixed `ioInput`/`ioOutput` word pair of the final datapath stage. It sits on the data-memory port of the top-level stage and decodes a small address window into `NCH` independent channels. Each input channel has a `valid/ready` handshake and a FIFO. Each output channel is a holding register that stays valid until the consumer takes the word. Status, error and optional interrupt registers let programs poll or wait on channels without losing data.

## Interface
Parameters:
- `DATA_W`, default 16: data width of the bus and of every channel.
- `ADDR_W`, default 16: width of the memory address.
- `NCH`, default 4: channel count. Legal range is 1..`DATA_W`/2.
- `IN_DEPTH`, default 4: depth of each input FIFO. Must be a power of 2, at least 2.
- `BASE_ADDR`, default 16'hFF00: word address of register offset 0.

Ports (clock and reset first):
- `CLK` in 1: clock.
- `reset` in 1: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `memAddr` in `ADDR_W`: access address.
- `writeMem` in 1: write strobe.
- `readMem` in 1: read strobe.
- `memWriteData` in `DATA_W`: write data.
- `ioRdata` out `DATA_W`: registered read data.
- `ioHit` out 1: combinational flag, high when `memAddr` falls inside the window.
- `ioInput` in `NCH*DATA_W`: input data. Channel c occupies bits `[c*DATA_W +: DATA_W]`.
- `ioInValid` in `NCH`: producer valid, one bit per channel.
- `ioInReady` out `NCH`: FIFO not full, one bit per channel.
- `ioOutput` out `NCH*DATA_W`: output holding registers, packed like `ioInput`.
- `ioOutValid` out `NCH`: output word valid, one bit per channel.
- `ioOutReady` in `NCH`: consumer ready, one bit per channel.
- `ioIrq` out 1: interrupt request.

## Operation
Register map, as offsets from `BASE_ADDR`:
- Offset c, for c = 0..`NCH-1`: channel data.
  - Read pops the head of input FIFO c.
  - Write loads output register c.
- Offset `NCH`: status, read-only.
  - Bits `[NCH-1:0]`: input FIFO c is not empty.
  - Bits `[2NCH-1:NCH]`: `ioOutValid[c]`.
  - Remaining bits read 0.
- Offset `NCH+1`: error register, write-1-to-clear.
  - Bit c is set when channel c is written while `ioOutValid[c]` is already 1.
- Offset `NCH+2`: interrupt mask, read/write. Bits `[NCH-1:0]`; remaining bits read 0.

Input path:
- A word is pushed into FIFO c when `ioInValid[c] & ioInReady[c]` is high at a clock edge.
- `ioInReady[c]` is `!full`, derived only from registered state.
- A pop and a push in the same cycle are both performed; the count is unchanged.
- Reading an empty FIFO returns 0 and changes no state.
- The pointers are `log2(IN_DEPTH)` bits wide and wrap modulo `IN_DEPTH`.

Output path:
- A write to offset c when `ioOutValid[c]` is 0 loads the word and sets `ioOutValid[c]` at the next edge.
- A write while `ioOutValid[c]` is 1 is discarded; `ioOutput` is unchanged and error bit c is set.
- `ioOutValid[c]` clears on the edge where `ioOutValid[c] & ioOutReady[c]` is high.
- If that handshake completes in the same cycle as a new write to c, the new word loads and valid stays 1. No error is raised.

Bus behaviour:
- Accesses outside the window are ignored, and `ioRdata` returns 0.
- `readMem` and `writeMem` may be high in the same cycle:
  - The read returns the pre-write value of the register.
  - Both side effects (pop, load, W1C) take place.
- Interrupt: `ioIrq` is the OR over c of (FIFO c not empty AND mask[c]). It is registered.

Reset values:
- All FIFOs empty, so `ioInReady` = all 1 from the first cycle after reset.
- `ioOutput` = 0 and `ioOutValid` = 0.
- `ioRdata` = 0, error register = 0, mask = 0, `ioIrq` = 0.
- Reset asserted mid-transfer discards all FIFO contents and any pending output word.

## Timing
- Read latency is 1 cycle: `ioRdata` is valid on the cycle after `readMem`, and holds until the next read.
- The pop takes effect at the same edge that captures `ioRdata`.
- Write-to-`ioOutValid` latency: 1 edge.
- Input-push-to-status latency: status bit c is visible to a read issued on the cycle after the push edge.
- Full throughput is one push and one pop per channel per cycle.
- `ioIrq` lags the FIFO state by 1 cycle.

## Configuration
- Macro `IO_PORT_IRQ_EN`.
- Defined: the mask register and `ioIrq` behave as described above.
- Undefined:
  - `ioIrq` is tied to 0.
  - Offset `NCH+2` reads 0 and ignores writes.
  - The window still spans `NCH+3` words, so the register map does not move.

## Test plan
- **Reset, then read status.** `NCH`=4, 16-bit. Read `BASE+4` one cycle after reset drops.
  - Required: `ioRdata` = 16'h0000, `ioInReady` = 4'b1111, `ioOutValid` = 0.
- **Fill input channel 1.**
  - Stimulus: push 16'hA001..A005 on channel 1 with `ioInValid[1]` held high.
  - Required: 4 words are accepted; `ioInReady[1]` falls after the 4th.
  - Then four reads of `BASE+1` return A001..A004, in order and one cycle apart.
  - A 5th read returns 0 and causes no pop.
- **Output handshake with overrun.**
  - Stimulus: write 16'h1234 to `BASE+2`, hold `ioOutReady[2]` = 0, then write 16'h5678.
  - Required: `ioOutput` ch2 stays 1234; error reads 16'h0004.
  - Writing 16'h0004 to `BASE+5` clears it. Raising `ioOutReady[2]` drops `ioOutValid[2]` one edge later.
- **Write on the handshake edge.**
  - Stimulus: write 16'hBEEF to channel 0 on the same cycle that `ioOutValid[0] & ioOutReady[0]` is high.
  - Required: `ioOutput` ch0 = BEEF, valid stays 1, error = 0.
- **Interrupt (with `IO_PORT_IRQ_EN`).**
  - Stimulus: write mask 16'h0008, then push one word on channel 3.
  - Required: `ioIrq` rises 1 cycle after the push and falls 1 cycle after the pop.
  - Without the macro: `ioIrq` stays 0 and `BASE+6` reads 0.
